// File: rtl/w25_spi_pkg.sv
// w25_spi_pkg: shared state type and constants for the W25-style SPI responder
//   W25_IDLE_BYTE       byte returned when local logic has nothing queued
//   W25_SYNC_STAGES     default synchronizer depth per input pin
//   W25_MIN_HALF_PERIOD shortest legal SCLK high/low time in clk cycles
package w25_spi_pkg;
    typedef enum logic {IDLE, ACTIVE} w25_state_t;
    localparam logic [7:0] W25_IDLE_BYTE = 8'hFF;
    localparam int W25_SYNC_STAGES = 2;
    localparam int W25_MIN_HALF_PERIOD = W25_SYNC_STAGES + 3;
endpackage

// File: rtl/w25_sync_bit.sv
// w25_sync_bit: N-stage single-bit synchronizer with a chosen reset value
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output
module w25_sync_bit #(
    parameter int N = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] ff;
    always_ff @(posedge clk)
        ff <= rst ? {N{RST_VAL}} : {ff[N-2:0], d};
    assign q = ff[N-1];
endmodule

// File: rtl/w25_spi_slave.sv
// w25_spi_slave: SPI mode-0 responder with byte-level valid/ready interfaces
//   clk, rst                     : system clock, synchronous active-high reset
//   pin_cs_n, pin_sclk, pin_mosi : asynchronous SPI pins from the master
//   pin_miso, pin_miso_oe        : registered MISO and its output enable
//   tx_data, tx_valid, tx_ready  : byte to return, accepted into a holding register
//   rx_data, rx_valid            : received byte and its one-cycle strobe
//   sof, eof, tx_underrun        : frame start/end and idle-byte substitution strobes
module w25_spi_slave
    import w25_spi_pkg::*;
#(
    parameter int SYNC_STAGES = W25_SYNC_STAGES,
    parameter logic [7:0] IDLE_BYTE = W25_IDLE_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin_cs_n,
    input  logic       pin_sclk,
    input  logic       pin_mosi,
    output logic       pin_miso,
    output logic       pin_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       sof,
    output logic       eof,
    output logic       tx_underrun
);
    w25_state_t state_q, state_d;
    logic cs_s, sclk_s, mosi_s, cs_d, sclk_d;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] vld;
    logic armed;
    logic [7:0] hold, tx_shift, load_byte;
    logic hold_full;
    logic [6:0] rx_shift;
    logic [2:0] bitcnt;
    logic go, stop, bit_in, bit_out, byte_done, load;

    w25_sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_cs   (.clk(clk), .rst(rst), .d(pin_cs_n), .q(cs_s));
    w25_sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(clk), .rst(rst), .d(pin_sclk), .q(sclk_s));
    w25_sync_bit #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(clk), .rst(rst), .d(pin_mosi), .q(mosi_s));

    assign tx_ready = ~hold_full;

    always_comb begin
        go        = cs_fall & (state_q == IDLE);
        stop      = cs_rise & (state_q == ACTIVE);
        bit_in    = sclk_rise & (state_q == ACTIVE) & ~cs_rise;
        bit_out   = sclk_fall & (state_q == ACTIVE) & ~cs_rise;
        byte_done = bit_in & (bitcnt == 3'd7);
        load      = go | byte_done;
        load_byte = hold_full ? hold : IDLE_BYTE;
        state_d   = go ? ACTIVE : stop ? IDLE : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cs_d        <= 1'b1;
            sclk_d      <= 1'b0;
            vld         <= '0;
            armed       <= 1'b0;
            cs_fall     <= 1'b0;
            cs_rise     <= 1'b0;
            sclk_rise   <= 1'b0;
            sclk_fall   <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= IDLE_BYTE;
            rx_shift    <= '0;
            bitcnt      <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            sof         <= 1'b0;
            eof         <= 1'b0;
            tx_underrun <= 1'b0;
            pin_miso    <= 1'b1;
            pin_miso_oe <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_d        <= cs_s;
            sclk_d      <= sclk_s;
            // A CS that is already low when reset releases must not look like a
            // new frame: accept falls only after CS has been seen high once the
            // synchronizer has flushed its reset value.
            vld         <= {vld[SYNC_STAGES-2:0], 1'b1};
            armed       <= armed | (vld[SYNC_STAGES-1] & cs_s);
            cs_fall     <= armed & cs_d & ~cs_s;
            cs_rise     <= ~cs_d & cs_s;
            sclk_rise   <= ~sclk_d & sclk_s;
            sclk_fall   <= sclk_d & ~sclk_s;
            rx_valid    <= byte_done;
            sof         <= go;
            eof         <= stop;
            tx_underrun <= load & ~hold_full;
            // Accept only when empty, so a load and an accept never target a full register.
            hold_full   <= hold_full ? ~load : tx_valid;
            if (tx_valid & ~hold_full)
                hold <= tx_data;
            if (load)
                tx_shift <= load_byte;
            if (bit_in) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bitcnt   <= bitcnt + 3'd1;
            end
            if (byte_done)
                rx_data <= {rx_shift, mosi_s};
            if (go) begin
                bitcnt      <= '0;
                pin_miso    <= load_byte[7];
                pin_miso_oe <= 1'b1;
            end
            if (bit_out)
                pin_miso <= tx_shift[3'd7 - bitcnt];
            if (cs_rise) begin
                bitcnt      <= '0;
                pin_miso    <= 1'b1;
                pin_miso_oe <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_w25_spi_slave.sv
// tb_w25_spi_slave: randomized bench for w25_spi_slave against a byte-level SPI master model
module tb_w25_spi_slave;
    import w25_spi_pkg::*;
    localparam int HP = 6;

    logic clk = 1'b0, rst = 1'b1;
    logic pin_cs_n = 1'b1, pin_sclk = 1'b0, pin_mosi = 1'b0;
    logic pin_miso, pin_miso_oe, tx_ready, rx_valid, sof, eof, tx_underrun;
    logic [7:0] tx_data = 8'h00, rx_data;
    logic tx_valid = 1'b0;

    int total = 0, bad = 0;
    int n_rx = 0, n_sof = 0, n_eof = 0, n_und = 0;
    int s_rx, s_sof, s_eof, s_und, r0;
    logic [7:0] rx_q[$], m_out[$], m_in[$], exp_in[$];

    w25_spi_slave dut (
        .clk(clk), .rst(rst), .pin_cs_n(pin_cs_n), .pin_sclk(pin_sclk), .pin_mosi(pin_mosi),
        .pin_miso(pin_miso), .pin_miso_oe(pin_miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .sof(sof), .eof(eof),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)
            rx_q.push_back(rx_data);
        n_rx  <= n_rx + int'(rx_valid);
        n_sof <= n_sof + int'(sof);
        n_eof <= n_eof + int'(eof);
        n_und <= n_und + int'(tx_underrun);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        s_rx = n_rx; s_sof = n_sof; s_eof = n_eof; s_und = n_und;
    endtask

    task automatic deltas(input string tag, input int rx, input int so, input int eo, input int un);
        check({tag, "_nrx"}, n_rx - s_rx, rx);
        check({tag, "_nsof"}, n_sof - s_sof, so);
        check({tag, "_neof"}, n_eof - s_eof, eo);
        check({tag, "_nund"}, n_und - s_und, un);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        while (!tx_ready && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) begin
            total++;
            bad++;
            $display("FAIL tx_accept got=not_ready exp=ready byte=%0h", b);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Master side: shifts m_out MSB first, captures MISO on each SCLK rise into m_in.
    task automatic frame(input int hp, input int rises, input int rst_at);
        logic [7:0] cur = 8'h00;
        m_in.delete();
        pin_cs_n = 1'b0;
        pin_mosi = m_out[0][7];
        tick(hp);
        for (int i = 0; i < rises; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                @(negedge clk);
                check("rst_miso", pin_miso, 1);
                check("rst_oe", pin_miso_oe, 0);
                check("rst_tx_ready", tx_ready, 1);
                check("rst_rx_data", rx_data, 0);
                check("rst_rx_valid", rx_valid, 0);
                snap();
            end
            if (i == 0)
                check("oe_active", pin_miso_oe, 1);
            pin_sclk = 1'b1;
            cur = {cur[6:0], pin_miso};
            if (i % 8 == 7)
                m_in.push_back(cur);
            tick(hp);
            pin_sclk = 1'b0;
            if (i + 1 < rises)
                pin_mosi = m_out[(i + 1) / 8][7 - ((i + 1) % 8)];
            tick(hp);
        end
        if (rst_at >= 0)
            deltas("rst_quiet", 0, 0, 0, 0);
        pin_cs_n = 1'b1;
        tick(3 * hp);
    endtask

    task automatic verify(input string tag, input int rx_base, input int nb);
        logic [31:0] g;
        for (int i = 0; i < nb; i++) begin
            g = (rx_base + i < rx_q.size()) ? 32'(rx_q[rx_base + i]) : 32'hDEAD;
            check($sformatf("%s_rx%0d", tag, i), g, 32'(m_out[i]));
            g = (i < m_in.size()) ? 32'(m_in[i]) : 32'hDEAD;
            check($sformatf("%s_miso%0d", tag, i), g, 32'(exp_in[i]));
        end
        check({tag, "_oe_off"}, pin_miso_oe, 0);
        check({tag, "_miso_idle"}, pin_miso, 1);
    endtask

    initial begin
        tick(4);
        rst = 1'b0;
        tick(6);
        check("reset_miso", pin_miso, 1);
        check("reset_oe", pin_miso_oe, 0);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_rx_data", rx_data, 0);
        check("reset_strobes", {rx_valid, sof, eof, tx_underrun}, 0);

        // Single byte: the byte-boundary reload finds the holding register empty.
        push_tx(8'hA5);
        m_out = '{8'h3C}; exp_in = '{8'hA5};
        snap(); r0 = rx_q.size();
        frame(HP, 8, -1);
        verify("single", r0, 1);
        deltas("single", 1, 1, 1, 1);

        // Back-to-back: a fourth byte keeps the last reload from underrunning.
        m_out = '{8'h9F, 8'h00, 8'h00}; exp_in = '{8'h01, 8'h02, 8'h03};
        snap(); r0 = rx_q.size();
        fork
            begin
                push_tx(8'h01); push_tx(8'h02); push_tx(8'h03); push_tx(8'h04);
            end
            frame(HP, 24, -1);
        join
        verify("b2b", r0, 3);
        deltas("b2b", 3, 1, 1, 0);

        // Underrun at CS fall; a late byte lands in the second slot.
        m_out = '{8'h55, 8'hAA}; exp_in = '{8'hFF, 8'h5A};
        snap(); r0 = rx_q.size();
        fork
            begin
                tick(10); push_tx(8'h5A);
            end
            frame(HP, 16, -1);
        join
        verify("under", r0, 2);
        deltas("under", 2, 1, 1, 2);

        // Abort after five rises, then a clean frame.
        m_out = '{8'($urandom)};
        snap();
        frame(HP, 5, -1);
        deltas("abort", 0, 1, 1, 1);
        check("abort_oe", pin_miso_oe, 0);
        push_tx(8'h3D);
        m_out = '{8'hC3}; exp_in = '{8'h3D};
        snap(); r0 = rx_q.size();
        frame(HP, 8, -1);
        verify("post_abort", r0, 1);
        deltas("post_abort", 1, 1, 1, 1);

        // Reset after bit 3 while CS stays low.
        m_out = '{8'($urandom)};
        fork
            begin
                push_tx(8'h11); push_tx(8'h22);
            end
            frame(HP, 8, 3);
        join
        push_tx(8'h99);
        m_out = '{8'h66}; exp_in = '{8'h99};
        snap(); r0 = rx_q.size();
        frame(HP, 8, -1);
        verify("post_rst", r0, 1);
        deltas("post_rst", 1, 1, 1, 1);

        // Minimum half period, 256 random bytes each way.
        m_out.delete(); exp_in.delete();
        for (int i = 0; i < 256; i++) begin
            m_out.push_back(8'($urandom));
            exp_in.push_back(8'($urandom));
        end
        push_tx(exp_in[0]);
        snap(); r0 = rx_q.size();
        fork
            for (int i = 1; i < 256; i++)
                push_tx(exp_in[i]);
            frame(W25_MIN_HALF_PERIOD, 2048, -1);
        join
        verify("rand", r0, 256);
        deltas("rand", 256, 1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
